fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of `instruction_mem` and directly upstream of decode. It owns the PC and sequences read requests to the slow instruction memory with an enable-rising-edge / valid-pulse handshake. It buffers returned instructions in a 2-entry FIFO and presents them to decode with a valid/ready handshake. It also handles control-flow redirects from execute, including discarding a response that is already in flight.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, sequences enable-edge/valid-pulse reads to
// instruction memory, buffers two responses and hands them to decode with valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_enable,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [31:0]        pc, pc_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [31:0]        tail_instr, tail_instr_n;
    logic [31:0]        tail_pc, tail_pc_n;
    logic               imem_enable_n;
    logic [31:0]        imem_address_n;
    logic               if_valid_n;
    logic [31:0]        if_instr_n, if_pc_n;

    logic               pop, push, issue_ok;
    logic [CNT_W-1:0]   occ_after;

    // State and output registers; if_instr/if_pc double as the FIFO head entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            count        <= '0;
            tail_instr   <= '0;
            tail_pc      <= '0;
            imem_enable  <= 1'b0;
            imem_address <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            count        <= count_n;
            tail_instr   <= tail_instr_n;
            tail_pc      <= tail_pc_n;
            imem_enable  <= imem_enable_n;
            imem_address <= imem_address_n;
            if_valid     <= if_valid_n;
            if_instr     <= if_instr_n;
            if_pc        <= if_pc_n;
        end
    end

    // Next-state: FIFO bookkeeping, issue decision and request sequencing.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        count_n        = count;
        tail_instr_n   = tail_instr;
        tail_pc_n      = tail_pc;
        imem_enable_n  = imem_enable;
        imem_address_n = imem_address;
        if_instr_n     = if_instr;
        if_pc_n        = if_pc;

        pop       = if_valid && id_ready && !redirect;
        push      = (state == REQ) && imem_valid && !redirect;
        occ_after = redirect ? CNT_W'(0) : CNT_W'(count - (pop ? CNT_W'(1) : CNT_W'(0)));
        issue_ok  = occ_after < CNT_W'(2);

        if (redirect) begin
            count_n = '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == CNT_W'(1)) begin
                        if_instr_n = imem_data;
                        if_pc_n    = imem_address;
                    end else begin
                        if_instr_n   = tail_instr;
                        if_pc_n      = tail_pc;
                        tail_instr_n = imem_data;
                        tail_pc_n    = imem_address;
                    end
                end
                2'b10: begin
                    if (count == CNT_W'(0)) begin
                        if_instr_n = imem_data;
                        if_pc_n    = imem_address;
                    end else begin
                        tail_instr_n = imem_data;
                        tail_pc_n    = imem_address;
                    end
                    count_n = CNT_W'(count + CNT_W'(1));
                end
                2'b01: begin
                    if_instr_n = tail_instr;
                    if_pc_n    = tail_pc;
                    count_n    = CNT_W'(count - CNT_W'(1));
                end
                default: ;
            endcase
        end
        if_valid_n = (count_n != CNT_W'(0));

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_n           = redirect_pc;
                    imem_enable_n  = 1'b1;
                    imem_address_n = redirect_pc;
                    state_n        = REQ;
                end else if (issue_ok) begin
                    imem_enable_n  = 1'b1;
                    imem_address_n = pc;
                    state_n        = REQ;
                end
            end
            REQ: begin
                if (imem_valid) begin
                    imem_enable_n = 1'b0;
                    state_n       = GAP;
                    pc_n          = redirect ? redirect_pc : pc + PC_STEP;
                end else if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = DRAIN;
                end
            end
            // One low cycle gives memory a fresh rising edge; a redirect defers issue by a cycle.
            GAP: begin
                if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = IDLE;
                end else if (issue_ok) begin
                    imem_enable_n  = 1'b1;
                    imem_address_n = pc;
                    state_n        = REQ;
                end else begin
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_n = redirect_pc;
                end
                if (imem_valid) begin
                    imem_enable_n = 1'b0;
                    state_n       = GAP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory model, manual
// response injection, and a monitor recording requests and decode pops.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_enable;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    int tests = 0;
    int fails = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_enable  (imem_enable),
        .imem_address (imem_address),
        .imem_data    (imem_data),
        .imem_valid   (imem_valid),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready)
    );

    always #5 clock = ~clock;

    // Memory model: data = 0xA + address/4, returned mem_lat cycles after an enable rise.
    logic        mem_auto;
    int          mem_lat;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic        busy = 1'b0;
    logic        en_q = 1'b0;
    int          mem_cnt = 0;
    logic        man_valid;
    logic [31:0] man_data;

    assign imem_valid = mem_valid | man_valid;
    assign imem_data  = man_valid ? man_data : mem_data;

    always @(negedge clock) begin
        en_q      <= imem_enable;
        mem_valid <= 1'b0;
        if (!mem_auto) begin
            busy <= 1'b0;
        end else if (busy) begin
            if (mem_cnt <= 1) begin
                mem_valid <= 1'b1;
                mem_data  <= 32'hA + (imem_address >> 2);
                busy      <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (imem_enable && !en_q) begin
            busy    <= 1'b1;
            mem_cnt <= mem_lat;
        end
    end

    // Monitor: request addresses, low-run lengths between requests, decode pops.
    logic [31:0] issued[$];
    int          lowruns[$];
    logic [31:0] pop_instr[$];
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];
    int          cyc = 0;
    int          low_cnt = 0;
    logic        seen = 1'b0;
    logic        en_mon = 1'b0;
    logic [31:0] addr_mon = '0;
    logic        addr_moved = 1'b0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        en_mon   <= imem_enable;
        addr_mon <= imem_address;
        if (imem_enable && en_mon && imem_address != addr_mon) addr_moved <= 1'b1;
        if (!reset_n) begin
            issued.delete(); lowruns.delete();
            pop_instr.delete(); pop_pc.delete(); pop_cyc.delete();
            seen    <= 1'b0;
            low_cnt <= 0;
        end else begin
            if (imem_enable && !en_mon) begin
                if (seen) lowruns.push_back(low_cnt);
                seen <= 1'b1;
                issued.push_back(imem_address);
            end
            low_cnt <= imem_enable ? 0 : low_cnt + 1;
            if (if_valid && id_ready) begin
                pop_instr.push_back(if_instr);
                pop_pc.push_back(if_pc);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        man_valid = 1'b0; man_data = '0; mem_auto = 1'b1; mem_lat = 2;

        // Reset values.
        repeat (2) @(negedge clock);
        chk("rst_enable", 32'(imem_enable), 32'd0);
        chk("rst_address", imem_address, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);

        // Sequential fetch with decode always ready.
        reset_n = 1'b1;
        for (int i = 0; i < 200 && pop_pc.size() < 3; i++) @(negedge clock);
        chk("t1_timeout", 32'(pop_pc.size() >= 3), 32'd1);
        chk("t1_instr0", pop_instr[0], 32'hA);  chk("t1_pc0", pop_pc[0], 32'h0);
        chk("t1_instr1", pop_instr[1], 32'hB);  chk("t1_pc1", pop_pc[1], 32'h4);
        chk("t1_instr2", pop_instr[2], 32'hC);  chk("t1_pc2", pop_pc[2], 32'h8);
        chk("t1_addr0", issued[0], 32'h0);
        chk("t1_addr1", issued[1], 32'h4);
        chk("t1_addr2", issued[2], 32'h8);
        chk("t1_gap0", 32'(lowruns[0]), 32'd1);
        chk("t1_gap1", 32'(lowruns[1]), 32'd1);

        // Decode stalled: two reads fill the buffer, then fetch stops.
        id_ready = 1'b0;
        do_reset();
        repeat (60) @(negedge clock);
        chk("t2_reads", 32'(issued.size()), 32'd2);
        chk("t2_enable_low", 32'(imem_enable), 32'd0);
        chk("t2_if_valid", 32'(if_valid), 32'd1);
        chk("t2_head_instr", if_instr, 32'hA);
        chk("t2_head_pc", if_pc, 32'h0);
        id_ready = 1'b1;
        for (int i = 0; i < 100 && issued.size() < 3; i++) @(negedge clock);
        chk("t2_pop0", pop_instr[0], 32'hA);
        chk("t2_pop1", pop_instr[1], 32'hB);
        chk("t2_pop_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
        chk("t2_resume_addr", issued[2], 32'h8);

        // Redirect while a slow read of address 4 is in flight.
        mem_lat = 8;
        do_reset();
        for (int i = 0; i < 200 && issued.size() < 2; i++) @(negedge clock);
        chk("t3_second_req", 32'(issued.size()), 32'd2);
        repeat (3) @(negedge clock);
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clock);
        redirect = 1'b0;
        chk("t3_drain_enable", 32'(imem_enable), 32'd1);
        chk("t3_drain_addr", imem_address, 32'h4);
        for (int i = 0; i < 200 && pop_pc.size() < 2; i++) @(negedge clock);
        chk("t3_new_addr", issued[2], 32'h40);
        chk("t3_pop0_pc", pop_pc[0], 32'h0);
        chk("t3_pop1_pc", pop_pc[1], 32'h40);
        chk("t3_pop1_instr", pop_instr[1], 32'h1A);
        chk("t3_addr_stable", 32'(addr_moved), 32'd0);

        // Redirect coinciding with imem_valid (manual memory from here on).
        reset_n = 1'b0; mem_auto = 1'b0; id_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("t4_req_addr", imem_address, 32'h0);
        @(negedge clock);
        man_valid = 1'b1; man_data = 32'hDEAD; redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clock);
        man_valid = 1'b0; redirect = 1'b0;
        chk("t4_gap_enable", 32'(imem_enable), 32'd0);
        chk("t4_dropped", 32'(if_valid), 32'd0);
        @(negedge clock);
        chk("t4_req_enable", 32'(imem_enable), 32'd1);
        chk("t4_req_addr40", imem_address, 32'h40);
        man_valid = 1'b1; man_data = 32'h1234;
        @(negedge clock);
        man_valid = 1'b0;
        chk("t4_lat_valid", 32'(if_valid), 32'd1);
        chk("t4_lat_instr", if_instr, 32'h1234);
        chk("t4_lat_pc", if_pc, 32'h40);

        // Fill both entries, then redirect with decode ready: buffer flushed, no pop.
        @(negedge clock);
        chk("t5_req_addr44", imem_address, 32'h44);
        man_valid = 1'b1; man_data = 32'h5678;
        @(negedge clock);
        man_valid = 1'b0;
        @(negedge clock);
        chk("t5_full_stall", 32'(imem_enable), 32'd0);
        chk("t5_head_hold", if_instr, 32'h1234);
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        @(negedge clock);
        id_ready = 1'b0; redirect = 1'b0;
        chk("t5_flush_valid", 32'(if_valid), 32'd0);
        chk("t5_idle_redirect_en", 32'(imem_enable), 32'd1);
        chk("t5_idle_redirect_addr", imem_address, 32'h80);
        man_valid = 1'b1; man_data = 32'h33;
        @(negedge clock);
        man_valid = 1'b0;
        chk("t5_after_instr", if_instr, 32'h33);
        chk("t5_after_pc", if_pc, 32'h80);

        // Reset mid-request: asynchronous return to reset values, stray valid ignored.
        @(negedge clock);
        chk("t6_req_before_rst", 32'(imem_enable), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_async_enable", 32'(imem_enable), 32'd0);
        chk("t6_async_address", imem_address, 32'h0);
        chk("t6_async_if_valid", 32'(if_valid), 32'd0);
        chk("t6_async_if_pc", if_pc, 32'h0);
        @(negedge clock);
        reset_n = 1'b1; man_valid = 1'b1; man_data = 32'hBAD;
        @(negedge clock);
        man_valid = 1'b0;
        chk("t6_stray_ignored", 32'(if_valid), 32'd0);
        chk("t6_first_addr", imem_address, 32'h0);
        man_valid = 1'b1; man_data = 32'h44;
        @(negedge clock);
        man_valid = 1'b0;
        chk("t6_first_valid", 32'(if_valid), 32'd1);
        chk("t6_first_instr", if_instr, 32'h44);
        chk("t6_first_pc", if_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
